// File: rtl/sram_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_array_pkg
// Description : Shared types and helpers for the single-port SRAM array:
//               controller state encoding and write-mask expansion.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_array_pkg;

  // Controller states: CLEAR zeroes the array after reset, IDLE serves requests.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Upper bounds for the mask-expansion helper; callers slice the low bits.
  localparam int MAX_WIDTH = 1024;
  localparam int MAX_SEG   = 128;
  localparam int MAX_SEG_W = 7;

  // Expand a per-segment mask into a per-bit mask: bit i of the result takes
  // mask bit (i / seg_w). seg_w is a constant at every call site.
  function automatic logic [MAX_WIDTH-1:0] expand_mask(
    input logic [MAX_SEG-1:0] mask,
    input int                 seg_w
  );
    logic [MAX_WIDTH-1:0] r_bits;
    int                   seg;
    r_bits = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      seg = i / seg_w;
      if (seg < MAX_SEG) begin
        r_bits[i] = mask[seg[MAX_SEG_W-1:0]];
      end
    end
    return r_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_array_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_array_if
// Description : Request/response bundle of the single-port SRAM array.
//               The master issues requests; the slave is the array.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_array_if #(
  parameter int AW       = 7,
  parameter int WIDTH    = 100,
  parameter int MASK_SEG = 2
);
  logic                req_valid;
  logic                req_ready;
  logic                req_wmode;
  logic [AW-1:0]       req_addr;
  logic [MASK_SEG-1:0] req_wmask;
  logic [WIDTH-1:0]    req_wdata;
  logic                resp_valid;
  logic [WIDTH-1:0]    resp_rdata;
  logic                clear_busy;

  modport master (
    output req_valid, req_wmode, req_addr, req_wmask, req_wdata,
    input  req_ready, resp_valid, resp_rdata, clear_busy
  );

  modport slave (
    input  req_valid, req_wmode, req_addr, req_wmask, req_wdata,
    output req_ready, resp_valid, resp_rdata, clear_busy
  );
endinterface
`default_nettype wire

// File: rtl/sram_array_core.sv
`default_nettype none
// ============================================================================
// Module      : sram_array_core
// Description : Storage array with segment-masked write and a registered
//               read port (1-cycle latency). No reset: contents and the read
//               register only change on write / read enables.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_array_core
  import sram_array_pkg::*;
#(
  parameter  int DEPTH    = 128,
  parameter  int WIDTH    = 100,
  parameter  int MASK_SEG = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  wire logic                clock,
  input  wire logic                i_we,
  input  wire logic                i_re,
  input  wire logic [AW-1:0]       i_addr,
  input  wire logic [MASK_SEG-1:0] i_wmask,
  input  wire logic [WIDTH-1:0]    i_wdata,
  output logic      [WIDTH-1:0]    o_rdata
);

  localparam int c_SEG_W = WIDTH / MASK_SEG;

  logic [MAX_WIDTH-1:0] w_mask_full;
  logic [WIDTH-1:0]     w_bitmask;
  logic                 w_unused_mask_hi;
  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [WIDTH-1:0]     r_rdata;

  assign w_mask_full      = expand_mask(MAX_SEG'(i_wmask), c_SEG_W);
  assign w_bitmask        = w_mask_full[WIDTH-1:0];
  // Bits above WIDTH never reach the array.
  assign w_unused_mask_hi = ^{1'b0, w_mask_full};

  // Masked write: unselected bits keep their stored value.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= (r_mem[i_addr] & ~w_bitmask) | (i_wdata & w_bitmask);
    end
  end

  // Read register only loads on a read, so it holds between reads.
  always_ff @(posedge clock) begin
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sram_array_sp.sv
`default_nettype none
// ============================================================================
// Module      : sram_array_sp
// Description : Single-port SRAM array with valid/ready request handshake,
//               segment write mask, 1-cycle read response with held data,
//               and an optional post-reset zeroing sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_array_sp
  import sram_array_pkg::*;
#(
  parameter  int DEPTH          = 128,
  parameter  int WIDTH          = 100,
  parameter  int MASK_SEG       = 2,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int AW             = $clog2(DEPTH)
) (
  input  wire logic   clock,
  input  wire logic   reset_n,
  sram_array_if.slave bus
);

  localparam state_t          c_RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [AW-1:0]   c_LAST_ADDR   = AW'(DEPTH - 1);

  state_t              r_state;
  logic [AW-1:0]       r_clr_cnt;
  logic                r_ready;
  logic                r_busy;
  logic                r_resp_valid;
  logic                r_rdata_live;

  logic                w_clearing;
  logic                w_accept;
  logic                w_rd;
  logic                w_wr;
  logic                w_core_we;
  logic [AW-1:0]       w_core_addr;
  logic [MASK_SEG-1:0] w_core_mask;
  logic [WIDTH-1:0]    w_core_wdata;
  logic [WIDTH-1:0]    w_core_rdata;

  // r_ready is only high in IDLE, so nothing is accepted while clearing.
  assign w_clearing   = (r_state == ST_CLEAR);
  assign w_accept     = bus.req_valid & r_ready;
  assign w_rd         = w_accept & ~bus.req_wmode;
  assign w_wr         = w_accept &  bus.req_wmode;

  // The clear sequence owns the array port while it runs.
  assign w_core_we    = w_clearing | w_wr;
  assign w_core_addr  = w_clearing ? r_clr_cnt : bus.req_addr;
  assign w_core_mask  = w_clearing ? '1 : bus.req_wmask;
  assign w_core_wdata = w_clearing ? '0 : bus.req_wdata;

  sram_array_core #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .MASK_SEG (MASK_SEG)
  ) u_core (
    .clock   (clock),
    .i_we    (w_core_we),
    .i_re    (w_rd),
    .i_addr  (w_core_addr),
    .i_wmask (w_core_mask),
    .i_wdata (w_core_wdata),
    .o_rdata (w_core_rdata)
  );

  // Controller FSM, clear counter and registered handshake/response flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_RESET_STATE;
      r_clr_cnt    <= '0;
      r_ready      <= (c_RESET_STATE == ST_IDLE);
      r_busy       <= (c_RESET_STATE == ST_CLEAR);
      r_resp_valid <= 1'b0;
      r_rdata_live <= 1'b0;
    end else begin
      r_resp_valid <= w_rd;
      if (w_rd) begin
        r_rdata_live <= 1'b1;
      end
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == c_LAST_ADDR) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The core read register is not reset; report zero until the first read
  // after reset has landed.
  assign bus.resp_rdata = r_rdata_live ? w_core_rdata : '0;
  assign bus.resp_valid = r_resp_valid;
  assign bus.req_ready  = r_ready;
  assign bus.clear_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sram_array_sp.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_array_sp
// Description : Self-checking bench for sram_array_sp: default configuration
//               (with clear) and a 16x64, byte-masked, no-clear configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_array_sp;

  logic clk     = 1'b0;
  logic rst_a_n = 1'b1;
  logic rst_b_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  sram_array_if #(.AW(7), .WIDTH(100), .MASK_SEG(2)) ifa ();
  sram_array_if #(.AW(4), .WIDTH(64),  .MASK_SEG(8)) ifb ();

  sram_array_sp #(.DEPTH(128), .WIDTH(100), .MASK_SEG(2), .CLEAR_ON_RESET(1)) u_dut_a (
    .clock   (clk),
    .reset_n (rst_a_n),
    .bus     (ifa)
  );

  sram_array_sp #(.DEPTH(16), .WIDTH(64), .MASK_SEG(8), .CLEAR_ON_RESET(0)) u_dut_b (
    .clock   (clk),
    .reset_n (rst_b_n),
    .bus     (ifb)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- model of the default instance ----------------
  logic [99:0] ma_mem [128];
  int          ma_cyc;      // clock edges since reset release
  logic        ma_valid;
  logic [99:0] ma_rdata;

  always @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      ma_cyc   = 0;
      ma_valid = 1'b0;
      ma_rdata = '0;
    end else begin
      ma_valid = 1'b0;
      if (ma_cyc < 128) begin
        ma_mem[ma_cyc] = '0;
        ma_cyc++;
      end else if (ifa.req_valid) begin
        if (ifa.req_wmode) begin
          for (int s = 0; s < 2; s++)
            if (ifa.req_wmask[s]) ma_mem[ifa.req_addr][s*50 +: 50] = ifa.req_wdata[s*50 +: 50];
        end else begin
          ma_valid = 1'b1;
          ma_rdata = ma_mem[ifa.req_addr];
        end
      end
    end
  end

  // ---------------- model of the 16x64 instance ----------------
  logic [63:0] mb_mem   [16];
  logic [63:0] mb_known [16];
  logic        mb_valid;
  logic [63:0] mb_rdata;
  logic [63:0] mb_rknown;

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      mb_valid  = 1'b0;
      mb_rdata  = '0;
      mb_rknown = '1;
      for (int a = 0; a < 16; a++) mb_known[a] = '0;
    end else begin
      mb_valid = 1'b0;
      if (ifb.req_valid) begin
        if (ifb.req_wmode) begin
          for (int s = 0; s < 8; s++)
            if (ifb.req_wmask[s]) begin
              mb_mem[ifb.req_addr][s*8 +: 8]   = ifb.req_wdata[s*8 +: 8];
              mb_known[ifb.req_addr][s*8 +: 8] = 8'hFF;
            end
        end else begin
          mb_valid  = 1'b1;
          mb_rdata  = mb_mem[ifb.req_addr];
          mb_rknown = mb_known[ifb.req_addr];
        end
      end
    end
  end

  // Compare both DUTs against their models every cycle.
  always @(negedge clk) begin
    chk("a_ready", 128'(ifa.req_ready),  128'(ma_cyc >= 128));
    chk("a_busy",  128'(ifa.clear_busy), 128'(ma_cyc < 128));
    chk("a_valid", 128'(ifa.resp_valid), 128'(ma_valid));
    chk("a_rdata", 128'(ifa.resp_rdata), 128'(ma_rdata));
    chk("b_ready", 128'(ifb.req_ready),  128'(1'b1));
    chk("b_busy",  128'(ifb.clear_busy), 128'(1'b0));
    chk("b_valid", 128'(ifb.resp_valid), 128'(mb_valid));
    chk("b_rdata", 128'(ifb.resp_rdata & mb_rknown), 128'(mb_rdata & mb_rknown));
  end

  // ---------------- stimulus helpers ----------------
  task automatic a_wr(input logic [6:0] addr, input logic [99:0] d, input logic [1:0] m);
    ifa.req_valid = 1'b1; ifa.req_wmode = 1'b1;
    ifa.req_addr  = addr; ifa.req_wdata = d; ifa.req_wmask = m;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
  endtask

  task automatic a_rd(input logic [6:0] addr);
    ifa.req_valid = 1'b1; ifa.req_wmode = 1'b0; ifa.req_addr = addr;
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
  endtask

  task automatic b_wr(input logic [3:0] addr, input logic [63:0] d, input logic [7:0] m);
    ifb.req_valid = 1'b1; ifb.req_wmode = 1'b1;
    ifb.req_addr  = addr; ifb.req_wdata = d; ifb.req_wmask = m;
    @(posedge clk); #1;
    ifb.req_valid = 1'b0;
  endtask

  task automatic b_rd(input logic [3:0] addr);
    ifb.req_valid = 1'b1; ifb.req_wmode = 1'b0; ifb.req_addr = addr;
    @(posedge clk); #1;
    ifb.req_valid = 1'b0;
  endtask

  // Count cycles with clear_busy high, starting in the current cycle.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (!ifa.clear_busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [99:0] c_A = 100'hA5A5A5A5A5A5A5A5A5A5A5A5A;
  localparam logic [99:0] c_B = 100'h3C3C3C3C3C3C3C3C3C3C3C3C3;
  localparam logic [99:0] c_C = 100'h0123456789ABCDEF012345678;

  initial begin
    int n;
    logic [99:0] ones;
    ones = '1;
    ifa.req_valid = 1'b0; ifa.req_wmode = 1'b0; ifa.req_addr = '0;
    ifa.req_wmask = '0;   ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_wmode = 1'b0; ifb.req_addr = '0;
    ifb.req_wmask = '0;   ifb.req_wdata = '0;
    #2;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_reset_busy",  128'(ifa.clear_busy), 128'(1'b1));
    chk("a_reset_ready", 128'(ifa.req_ready),  128'(1'b0));
    chk("a_reset_valid", 128'(ifa.resp_valid), 128'(1'b0));
    chk("a_reset_rdata", 128'(ifa.resp_rdata), 128'(0));
    chk("b_reset_ready", 128'(ifb.req_ready),  128'(1'b1));

    // Clear lasts exactly DEPTH cycles, then zeroed reads.
    #2 rst_a_n = 1'b1;
    count_busy(n);
    chk("a_clear_len", 128'(n), 128'(128));
    chk("a_ready_after_clear", 128'(ifa.req_ready), 128'(1'b1));
    a_rd(7'd0);   @(negedge clk);
    chk("a_rd0_valid", 128'(ifa.resp_valid), 128'(1'b1));
    chk("a_rd0_data",  128'(ifa.resp_rdata), 128'(0));
    a_rd(7'd64);  @(negedge clk);
    chk("a_rd64_data", 128'(ifa.resp_rdata), 128'(0));
    a_rd(7'd127); @(negedge clk);
    chk("a_rd127_data", 128'(ifa.resp_rdata), 128'(0));

    // Low-segment write only.
    a_wr(7'd5, ones, 2'b01);
    a_rd(7'd5); @(negedge clk);
    chk("a_mask_lo_valid", 128'(ifa.resp_valid), 128'(1'b1));
    chk("a_mask_lo_data",  128'(ifa.resp_rdata), 128'({50'd0, {50{1'b1}}}));
    @(negedge clk);
    chk("a_valid_one_cycle", 128'(ifa.resp_valid), 128'(1'b0));

    // Read data holds across a write to the same address and idle cycles.
    a_wr(7'd3, c_A, 2'b11);
    a_rd(7'd3); @(negedge clk);
    chk("a_hold_first", 128'(ifa.resp_rdata), 128'(c_A));
    a_wr(7'd3, c_B, 2'b11);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("a_hold_after_idle", 128'(ifa.resp_rdata), 128'(c_A));
    a_rd(7'd3); @(negedge clk);
    chk("a_hold_next_read", 128'(ifa.resp_rdata), 128'(c_B));

    // Back-to-back write then read of the same address.
    a_wr(7'd9, c_C, 2'b11);
    a_rd(7'd9); @(negedge clk);
    chk("a_wr_rd_b2b", 128'(ifa.resp_rdata), 128'(c_C));
    a_wr(7'd9, '0, 2'b00);
    a_rd(7'd9); @(negedge clk);
    chk("a_zero_mask", 128'(ifa.resp_rdata), 128'(c_C));

    // Reset in the response cycle suppresses it.
    a_rd(7'd9);
    chk("a_resp_before_reset", 128'(ifa.resp_valid), 128'(1'b1));
    rst_a_n = 1'b0;
    #1;
    chk("a_resp_suppressed", 128'(ifa.resp_valid), 128'(1'b0));
    chk("a_rdata_reset",     128'(ifa.resp_rdata), 128'(0));

    // Hold a read request throughout; reset in the middle of the clear.
    ifa.req_valid = 1'b1; ifa.req_wmode = 1'b0; ifa.req_addr = 7'd5;
    @(negedge clk); #2 rst_a_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("a_midclear_busy", 128'(ifa.clear_busy), 128'(1'b1));
    #2 rst_a_n = 1'b0;
    @(negedge clk); #2 rst_a_n = 1'b1;
    count_busy(n);
    chk("a_restart_clear_len", 128'(n), 128'(128));
    @(negedge clk);
    chk("a_first_idle_accept", 128'(ifa.resp_valid), 128'(1'b1));
    chk("a_first_idle_data",   128'(ifa.resp_rdata), 128'(0));
    ifa.req_valid = 1'b0;

    // 16x64 byte-masked instance without clear.
    @(negedge clk); #2 rst_b_n = 1'b1;
    #1;
    chk("b_ready_after_reset", 128'(ifb.req_ready), 128'(1'b1));
    @(negedge clk);
    b_wr(4'd2, 64'h0123456789ABCDEF, 8'hFF);
    b_wr(4'd2, 64'hFFFFFFFFFFFFFFFF, 8'b10100101);
    b_rd(4'd2); @(negedge clk);
    chk("b_valid", 128'(ifb.resp_valid), 128'(1'b1));
    chk("b_byte_mask", 128'(ifb.resp_rdata), 128'(64'hFF23FF6789FFCDFF));
    b_wr(4'd2, 64'h0, 8'h00);
    b_rd(4'd2); @(negedge clk);
    chk("b_zero_mask", 128'(ifb.resp_rdata), 128'(64'hFF23FF6789FFCDFF));
    b_wr(4'd15, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    b_wr(4'd15, 64'h0, 8'h0F);
    b_wr(4'd15, 64'h5555555555555555, 8'h80);
    b_rd(4'd15); @(negedge clk);
    chk("b_top_addr", 128'(ifb.resp_rdata), 128'(64'h55AAAAAA00000000));
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
